hazard_scoreboard: RTL

Parametrised in-order hazard scoreboard that replaces the single-stage interlock at the ID/EX boundary. It tracks every in-flight register write across a DEPTH-stage back end (EX1..WB) with per-instruction result latency. For each source operand it decides whether to stall or forward from a specific stage. It also supports flush of younger entries and counts stall cycles for performance monitoring.

---
 rtl/hazard_scoreboard_pkg.sv | 36 +++
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_scoreboard_match.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// Entry widths follow the default register count and back-end depth below;
// the scoreboard and its lookup sub-module both import this package.
package hazard_pkg;

    localparam int HZ_NREG  = 32;
    localparam int HZ_DEPTH = 4;
    localparam int HZ_RW    = $clog2(HZ_NREG);
    localparam int HZ_SW    = $clog2(HZ_DEPTH + 1);

    // Operand source code meaning "read the register file, no bypass"
    localparam logic [HZ_SW-1:0] FWD_RF = '0;

    // One in-flight register write: destination and the stage where the
    // result first becomes available on the bypass network
    typedef struct packed {
        logic              valid;
        logic [HZ_RW-1:0]  rd;
        logic [HZ_SW-1:0]  lat;
    } entry_t;

    // A latency of 0 behaves like 1, anything beyond the last stage is
    // treated as available at writeback
    function automatic logic [HZ_SW-1:0] clampLat(input logic [HZ_SW-1:0] lat);
        logic [HZ_SW-1:0] w_lat;
        if (lat == '0) begin
            w_lat = HZ_SW'(1);
        end else if (lat > HZ_SW'(HZ_DEPTH)) begin
            w_lat = HZ_SW'(HZ_DEPTH);
        end else begin
            w_lat = lat;
        end
        return w_lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage and the hazard scoreboard.
// The ID stage is the master: it presents the instruction and reads back
// the stall/forward decision in the same cycle.
interface hazard_scoreboard_if #(
    parameter int CNTW = 32
);
    import hazard_pkg::*;

    logic                  issue_valid;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [HZ_RW-1:0]      rs1;
    logic [HZ_RW-1:0]      rs2;
    logic                  rd_we;
    logic [HZ_RW-1:0]      rd;
    logic [HZ_SW-1:0]      rd_lat;
    logic                  flush;

    logic                  stall;
    logic [HZ_SW-1:0]      fwd_rs1;
    logic [HZ_SW-1:0]      fwd_rs2;
    logic                  issue_fire;
    logic                  busy;
    logic [CNTW-1:0]       stall_cnt;

    modport master (
        output issue_valid, use_rs1, use_rs2, rs1, rs2,
               rd_we, rd, rd_lat, flush,
        input  stall, fwd_rs1, fwd_rs2, issue_fire, busy, stall_cnt
    );

    modport slave (
        input  issue_valid, use_rs1, use_rs2, rs1, rs2,
               rd_we, rd, rd_lat, flush,
        output stall, fwd_rs1, fwd_rs2, issue_fire, busy, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Per-operand producer lookup. Finds the youngest in-flight writer of the
// source register and decides between stalling, bypassing from that
// stage, or reading the register file.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = HZ_DEPTH
) (
    input  entry_t [DEPTH:1]  i_ent,
    input  logic [HZ_RW-1:0]  i_rs,
    input  logic              i_use,
    output logic              o_hazard,
    output logic [HZ_SW-1:0]  o_fwd
);

    logic              w_found;
    logic [HZ_SW-1:0]  w_stage;
    logic [HZ_SW-1:0]  w_lat;

    // Scan oldest to youngest so the lowest matching stage overwrites older matches
    always_comb begin
        w_found = 1'b0;
        w_stage = FWD_RF;
        w_lat   = '0;
        for (int s = DEPTH; s >= 1; s--) begin
            if (i_ent[s].valid && (i_ent[s].rd == i_rs)) begin
                w_found = 1'b1;
                w_stage = HZ_SW'(s);
                w_lat   = i_ent[s].lat;
            end
        end
    end

    // Result not yet produced means stall; otherwise bypass from the matching stage
    always_comb begin
        o_hazard = 1'b0;
        o_fwd    = FWD_RF;
        if (i_use && (i_rs != '0) && w_found) begin
            if (w_stage < w_lat) begin
                o_hazard = 1'b1;
            end else begin
                o_fwd = w_stage;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order hazard scoreboard for the ID/EX boundary. Keeps a shift pipeline
// of in-flight register writes (stage 1 = EX1 ... stage DEPTH = WB) and
// resolves each source operand to stall, bypass stage or register file.
// KILL must lie in 1..DEPTH-1; NREG/DEPTH must match the package widths.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG  = HZ_NREG,
    parameter int DEPTH = HZ_DEPTH,
    parameter int KILL  = 1,
    parameter int CNTW  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  bus
);

    localparam int RW = $clog2(NREG);

    entry_t [DEPTH:1]  r_ent;
    entry_t [DEPTH:1]  w_entNext;
    entry_t            w_newEnt;
    logic [CNTW-1:0]   r_stallCnt;

    logic              w_haz1;
    logic              w_haz2;
    logic [HZ_SW-1:0]  w_fwd1;
    logic [HZ_SW-1:0]  w_fwd2;
    logic              w_stall;
    logic              w_fire;
    logic              w_busy;
    logic              w_tracked;

    hazard_match #(
        .DEPTH (DEPTH)
    ) u_matchRs1 (
        .i_ent    (r_ent),
        .i_rs     (bus.rs1),
        .i_use    (bus.use_rs1),
        .o_hazard (w_haz1),
        .o_fwd    (w_fwd1)
    );

    hazard_match #(
        .DEPTH (DEPTH)
    ) u_matchRs2 (
        .i_ent    (r_ent),
        .i_rs     (bus.rs2),
        .i_use    (bus.use_rs2),
        .o_hazard (w_haz2),
        .o_fwd    (w_fwd2)
    );

    // Stall holds ID; flush kills the issuing instruction even when it could go
    always_comb begin
        w_stall = bus.issue_valid && (w_haz1 || w_haz2);
        w_fire  = bus.issue_valid && !w_stall && !bus.flush;
    end

    // Only real writes to a non-zero register occupy a scoreboard slot
    always_comb begin
        w_tracked = w_fire && bus.rd_we && (bus.rd != RW'(0));
        w_newEnt  = '0;
        if (w_tracked) begin
            w_newEnt.valid = 1'b1;
            w_newEnt.rd    = bus.rd;
            w_newEnt.lat   = clampLat(bus.rd_lat);
        end
    end

    // Advance every entry one stage, insert the new instruction, then apply the kill window
    always_comb begin
        w_entNext    = '0;
        w_entNext[1] = w_newEnt;
        for (int s = 2; s <= DEPTH; s++) begin
            w_entNext[s] = r_ent[s-1];
        end
        if (bus.flush) begin
            for (int s = 1; s <= KILL; s++) begin
                w_entNext[s] = '0;
            end
        end
    end

    // Entry pipeline register; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ent <= '0;
        end else begin
            r_ent <= w_entNext;
        end
    end

    // Saturating count of cycles where a live, unflushed instruction was held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (bus.issue_valid && w_stall && !bus.flush && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNTW'(1);
        end
    end

    // Scoreboard is busy while any stage still carries a pending write
    always_comb begin
        w_busy = 1'b0;
        for (int s = 1; s <= DEPTH; s++) begin
            w_busy = w_busy | r_ent[s].valid;
        end
    end

    assign bus.stall      = w_stall;
    assign bus.fwd_rs1    = w_fwd1;
    assign bus.fwd_rs2    = w_fwd2;
    assign bus.issue_fire = w_fire;
    assign bus.busy       = w_busy;
    assign bus.stall_cnt  = r_stallCnt;

endmodule
